// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared definitions for the EX/MEM stage: word width, LEGv8 opcodes, ALUOp codes, and the EX/MEM record.
// The macros are also visible to any file compiled after this one.
`ifndef EX_MEM_BRANCH_STAGE_DEFS
`define EX_MEM_BRANCH_STAGE_DEFS
`define WORD 64
`define LDUR 11'b11111000010
`define STUR 11'b11111000000
`define CBZ  11'b10110100000
`define B    11'b00010100000
`define ADD  11'b10001011000
`define SUB  11'b11001011000
`define AND  11'b10001010000
`define ORR  11'b10101010000
`endif

package ex_mem_branch_stage_pkg;

    localparam int WORD_W = `WORD;

    localparam logic [10:0] OP_LDUR = `LDUR;
    localparam logic [10:0] OP_STUR = `STUR;
    localparam logic [10:0] OP_CBZ  = `CBZ;
    localparam logic [10:0] OP_B    = `B;
    localparam logic [10:0] OP_ADD  = `ADD;
    localparam logic [10:0] OP_SUB  = `SUB;
    localparam logic [10:0] OP_AND  = `AND;
    localparam logic [10:0] OP_ORR  = `ORR;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] alu_result;
        logic [WORD_W-1:0] write_data;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } exmem_t;

    function automatic logic is_branch_op(input logic [10:0] op);
        return (op == OP_CBZ) || (op == OP_B);
    endfunction

endpackage

// File: rtl/ex_mem_branch_stage_squash.sv
// branch_squash_ctrl: owns the wrong-path squash counter and the one-cycle PC redirect pulse.
// A taken, non-discarded beat arms SQUASH_CYCLES discards; only accepted beats count down.
module branch_squash_ctrl #(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic taken,
    output logic discard,
    output logic redirect_pulse
);

    localparam int SQ_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

    logic [SQ_W-1:0] squash_cnt_q, squash_cnt_d;
    logic            redirect_q, redirect_d;

    assign discard        = (squash_cnt_q != '0);
    assign redirect_pulse = redirect_q;

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        redirect_d   = 1'b0;
        if (accept) begin
            if (discard) begin
                squash_cnt_d = squash_cnt_q - SQ_W'(1);
            end else if (taken) begin
                squash_cnt_d = SQ_W'(SQUASH_CYCLES);
                redirect_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_cnt_q <= '0;
            redirect_q   <= 1'b0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
            redirect_q   <= redirect_d;
        end
    end

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with valid/ready handshake, CBZ/B resolution and wrong-path squash.
// Optional `BRANCH_STATS_EN adds saturating stat_branches / stat_taken counters.
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int SQUASH_CYCLES = 2
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [10:0]       ex_opcode,
    input  logic [WORD_W-1:0] ex_alu_result,
    input  logic              ex_zero,
    input  logic [WORD_W-1:0] ex_branch_target,
    input  logic [WORD_W-1:0] ex_write_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] mem_pc,
    output logic [WORD_W-1:0] mem_alu_result,
    output logic [WORD_W-1:0] mem_write_data,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              pc_redirect,
    output logic [WORD_W-1:0] pc_redirect_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_taken
`endif
);

    exmem_t            exmem_q, exmem_d;
    logic              mem_valid_q, mem_valid_d;
    logic [WORD_W-1:0] target_q, target_d;

    logic accept, discard, load, is_branch, taken;

    assign is_branch = is_branch_op(ex_opcode);
    assign taken     = (ex_opcode == OP_B) || ((ex_opcode == OP_CBZ) && ex_zero);

    // While squashing, wrong-path beats are swallowed even if MEM is stalled.
    assign ex_ready = !mem_valid_q || mem_ready || discard;
    assign accept   = ex_valid && ex_ready;
    assign load     = accept && !discard;

    branch_squash_ctrl #(
        .SQUASH_CYCLES (SQUASH_CYCLES)
    ) u_squash (
        .clk            (clk),
        .rst_n          (rst_n),
        .accept         (accept),
        .taken          (taken),
        .discard        (discard),
        .redirect_pulse (pc_redirect)
    );

    always_comb begin
        exmem_d     = exmem_q;
        mem_valid_d = mem_valid_q;
        target_d    = target_q;
        if (load) begin
            mem_valid_d        = 1'b1;
            exmem_d.pc         = ex_pc;
            exmem_d.alu_result = ex_alu_result;
            exmem_d.write_data = ex_write_data;
            exmem_d.rd         = ex_rd;
            // Branches, taken or not, must not write anything in MEM/WB.
            exmem_d.reg_write  = ex_reg_write && !is_branch;
            exmem_d.mem_read   = ex_mem_read  && !is_branch;
            exmem_d.mem_write  = ex_mem_write && !is_branch;
            if (taken) begin
                target_d = ex_branch_target;
            end
        end else if (mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_q     <= '0;
            mem_valid_q <= 1'b0;
            target_q    <= '0;
        end else begin
            exmem_q     <= exmem_d;
            mem_valid_q <= mem_valid_d;
            target_q    <= target_d;
        end
    end

    assign mem_valid          = mem_valid_q;
    assign mem_pc             = exmem_q.pc;
    assign mem_alu_result     = exmem_q.alu_result;
    assign mem_write_data     = exmem_q.write_data;
    assign mem_rd             = exmem_q.rd;
    assign mem_reg_write      = exmem_q.reg_write;
    assign mem_mem_read       = exmem_q.mem_read;
    assign mem_mem_write      = exmem_q.mem_write;
    assign pc_redirect_target = target_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0] stat_taken_q, stat_taken_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_taken_d    = stat_taken_q;
        if (load && is_branch && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + CNT_W'(1);
        end
        if (load && taken && (stat_taken_q != '1)) begin
            stat_taken_d = stat_taken_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed bench for ex_mem_branch_stage: a default build (2-beat squash) and a no-squash build
// share one stimulus stream; each is checked against hand-computed expectations.
`timescale 1ns/1ps
module tb_ex_mem_branch_stage;
    import ex_mem_branch_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    logic [WORD_W-1:0] ex_pc, ex_alu_result, ex_branch_target, ex_write_data;
    logic [10:0]       ex_opcode;
    logic              ex_zero;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic              mem_ready;

    logic              ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, pc_redirect;
    logic [WORD_W-1:0] mem_pc, mem_alu_result, mem_write_data, pc_redirect_target;
    logic [4:0]        mem_rd;

    logic              ex_ready0, mem_valid0, mem_reg_write0, mem_mem_read0, mem_mem_write0, pc_redirect0;
    logic [WORD_W-1:0] mem_pc0, mem_alu_result0, mem_write_data0, pc_redirect_target0;
    logic [4:0]        mem_rd0;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_taken, stat_branches0, stat_taken0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_branch_stage #(.SQUASH_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .ex_branch_target(ex_branch_target), .ex_write_data(ex_write_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
    );

    ex_mem_branch_stage #(.SQUASH_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready0),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .ex_branch_target(ex_branch_target), .ex_write_data(ex_write_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid0), .mem_ready(mem_ready), .mem_pc(mem_pc0),
        .mem_alu_result(mem_alu_result0), .mem_write_data(mem_write_data0), .mem_rd(mem_rd0),
        .mem_reg_write(mem_reg_write0), .mem_mem_read(mem_mem_read0), .mem_mem_write(mem_mem_write0),
        .pc_redirect(pc_redirect0), .pc_redirect_target(pc_redirect_target0)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches0), .stat_taken(stat_taken0)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [10:0] op, input logic [63:0] pc, input logic [63:0] alu,
                         input logic zero, input logic [63:0] tgt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
        ex_valid         = 1'b1;
        ex_opcode        = op;
        ex_pc            = pc;
        ex_alu_result    = alu;
        ex_zero          = zero;
        ex_branch_target = tgt;
        ex_write_data    = 64'hA5A5;
        ex_rd            = rd;
        ex_reg_write     = rw;
        ex_mem_read      = mr;
        ex_mem_write     = mw;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        offer(OP_ADD, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle();
        repeat (3) tick();
        check("rst mem_valid", mem_valid, 0);
        check("rst pc_redirect", pc_redirect, 0);
        check("rst ex_ready", ex_ready, 1);
        check("rst mem_alu_result", mem_alu_result, 0);
        rst_n = 1'b1;
        tick();

        // 1: LDUR
        offer(OP_LDUR, 64'd8, 64'd80, 1'b0, 0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check("ldur mem_valid", mem_valid, 1);
        check("ldur mem_alu_result", mem_alu_result, 80);
        check("ldur mem_mem_read", mem_mem_read, 1);
        check("ldur mem_rd", mem_rd, 9);
        check("ldur pc_redirect", pc_redirect, 0);

        // 2: backpressure
        offer(OP_ADD, 64'd12, 64'd30, 1'b0, 0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0;
        offer(OP_SUB, 64'd16, 64'd0, 1'b1, 0, 5'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d ex_ready", i), ex_ready, 0);
            check($sformatf("bp%0d mem_alu_result", i), mem_alu_result, 30);
            tick();
        end
        check("bp held mem_alu_result", mem_alu_result, 30);
        mem_ready = 1'b1;
        #1;
        check("bp release ex_ready", ex_ready, 1);
        tick();
        idle();
        check("bp sub mem_valid", mem_valid, 1);
        check("bp sub mem_alu_result", mem_alu_result, 0);
        check("bp sub mem_rd", mem_rd, 2);
        tick();
        check("drain mem_valid", mem_valid, 0);

        // 3: CBZ taken, then two squashed beats (one while MEM is stalled)
        offer(OP_CBZ, 64'd16, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 5'd31, 1'b1, 1'b0, 1'b0);
        tick();
        check("cbz pc_redirect", pc_redirect, 1);
        check("cbz redirect_target", pc_redirect_target, 64'hFFFF_FFFF_FFFF_FFFC);
        check("cbz mem_reg_write", mem_reg_write, 0);
        mem_ready = 1'b0;
        offer(OP_ADD, 64'd20, 64'd5, 1'b0, 0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        check("squash ex_ready", ex_ready, 1);
        tick();
        check("squash1 pc_redirect", pc_redirect, 0);
        check("squash1 mem_pc held", mem_pc, 16);
        check("squash1 mem_alu held", mem_alu_result, 7);
        check("squash1 mem_valid", mem_valid, 1);
        mem_ready = 1'b1;
        offer(OP_B, 64'd24, 64'd0, 1'b0, 64'd280, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("squash2 mem_valid", mem_valid, 0);
        check("squash2 pc_redirect", pc_redirect, 0);
        check("squash2 mem_pc", mem_pc, 16);
        tick();
        check("squash post pc_redirect", pc_redirect, 0);
        check("squash post target", pc_redirect_target, 64'hFFFF_FFFF_FFFF_FFFC);

        // 4: CBZ not taken, ORR passes
        offer(OP_CBZ, 64'd40, 64'd9, 1'b0, 64'd52, 5'd31, 1'b1, 1'b0, 1'b0);
        tick();
        check("cbznt pc_redirect", pc_redirect, 0);
        check("cbznt mem_valid", mem_valid, 1);
        check("cbznt mem_reg_write", mem_reg_write, 0);
        offer(OP_ORR, 64'd44, 64'd30, 1'b0, 0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        check("orr mem_alu_result", mem_alu_result, 30);
        check("orr mem_reg_write", mem_reg_write, 1);
        check("orr mem_rd", mem_rd, 3);
        check("orr pc_redirect", pc_redirect, 0);
        tick();

        // 5: back-to-back B; no-squash build redirects twice, default build squashes the second
        offer(OP_B, 64'd48, 64'd0, 1'b0, 64'd280, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("b280 nosq pc_redirect", pc_redirect0, 1);
        check("b280 nosq target", pc_redirect_target0, 280);
        check("b280 pc_redirect", pc_redirect, 1);
        offer(OP_B, 64'd52, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF40, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("b-192 nosq pc_redirect", pc_redirect0, 1);
        check("b-192 nosq target", pc_redirect_target0, 64'hFFFF_FFFF_FFFF_FF40);
        check("b-192 squashed pc_redirect", pc_redirect, 0);
        check("b-192 squashed target", pc_redirect_target, 280);
        tick();
        check("b post nosq pc_redirect", pc_redirect0, 0);

        // 6: consume the last squash slot, take B, then reset mid-operation
        offer(OP_ADD, 64'd56, 64'd3, 1'b0, 0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        offer(OP_B, 64'd60, 64'd0, 1'b0, 64'd100, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("rstb pc_redirect", pc_redirect, 1);
        check("rstb target", pc_redirect_target, 100);
`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, 4);
        check("stat_taken", stat_taken, 3);
`endif
        rst_n = 1'b0;
        #1;
        check("rst mid pc_redirect", pc_redirect, 0);
        check("rst mid mem_valid", mem_valid, 0);
        check("rst mid squash_cnt", u_dut.u_squash.squash_cnt_q, 0);
        check("rst mid ex_ready", ex_ready, 1);
`ifdef BRANCH_STATS_EN
        check("rst mid stat_branches", stat_branches, 0);
        check("rst mid stat_taken", stat_taken, 0);
`endif
        tick();
        rst_n = 1'b1;
        offer(OP_ADD, 64'd64, 64'd1, 1'b0, 0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        check("post rst mem_valid", mem_valid, 1);
        check("post rst mem_alu_result", mem_alu_result, 1);
        check("post rst pc_redirect", pc_redirect, 0);
        tick();
        check("post rst idle pc_redirect", pc_redirect, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
